// File: rtl/dot_product_pkg.sv
// Shared constants and helpers for the dot_product block.
package dot_product_pkg;

    // Width of the accumulator and of the result port (int-compatible).
    localparam int SUM_W = 32;

    // Index counter width: max(1, clog2(n)) so N = 1 still gets a real bit.
    function automatic int idx_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dot_product_mac.sv
// Combinational multiply-accumulate slice: one signed DW x DW product,
// sign-extended to SUM_W bits, either loaded (clear) or added to acc_in.
module dot_product_mac
    import dot_product_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic signed [DW-1:0]    a,
    input  logic signed [DW-1:0]    b,
    input  logic signed [SUM_W-1:0] acc_in,
    input  logic                    clear,
    output logic signed [SUM_W-1:0] acc_out
);

    logic signed [2*DW-1:0]  prod;
    logic signed [SUM_W-1:0] prod_ext;

    // Full-precision product, then sign-extend and accumulate (wraps mod 2^32).
    always_comb begin
        prod     = (2*DW)'(a) * (2*DW)'(b);
        prod_ext = SUM_W'(prod);
        acc_out  = clear ? prod_ext : (acc_in + prod_ext);
    end

endmodule

// File: rtl/dot_product.sv
// Serial dot product: one element per enabled cycle, result registered on
// sum with a one-cycle done pulse at the end of each N-element pass.
module dot_product
    import dot_product_pkg::*;
#(
    parameter int N  = 2,
    parameter int DW = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic signed [DW-1:0]    inp1 [0:N-1],
    input  logic signed [DW-1:0]    inp2 [0:N-1],
    output logic signed [SUM_W-1:0] sum,
    output logic                    done
);

    localparam int             IW   = idx_width(N);
    localparam logic [IW-1:0]  LAST = IW'(N - 1);

    logic [IW-1:0]           idx_q, idx_d;
    logic signed [SUM_W-1:0] acc_q, acc_d;
    logic signed [SUM_W-1:0] sum_q, sum_d;
    logic                    done_q, done_d;

    logic signed [DW-1:0]    sel_a, sel_b;
    logic signed [SUM_W-1:0] mac_out;
    logic                    mac_clear;

    // Pick the operand pair addressed by the current index.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IW'(i)) begin
                sel_a = inp1[i];
                sel_b = inp2[i];
            end
        end
    end

    // Element 0 starts a fresh pass, so the old accumulator is discarded.
    assign mac_clear = (idx_q == '0);

    dot_product_mac #(
        .DW(DW)
    ) u_mac (
        .a      (sel_a),
        .b      (sel_b),
        .acc_in (acc_q),
        .clear  (mac_clear),
        .acc_out(mac_out)
    );

    // Index control: accumulate mid-pass, publish the result on the last element.
    always_comb begin
        idx_d  = idx_q;
        acc_d  = acc_q;
        sum_d  = sum_q;
        done_d = 1'b0;
        if (enable) begin
            if (idx_q == LAST) begin
                sum_d  = mac_out;
                done_d = 1'b1;
                idx_d  = '0;
            end else begin
                acc_d = mac_out;
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // State registers; reset wins over enable and abandons any partial pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q  <= '0;
            acc_q  <= '0;
            sum_q  <= '0;
            done_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            acc_q  <= acc_d;
            sum_q  <= sum_d;
            done_q <= done_d;
        end
    end

    assign sum  = sum_q;
    assign done = done_q;

endmodule

// File: tb/tb_dot_product.sv
// Bench for dot_product (N=2, DW=8): table vectors, directed pause/reset
// sequences, and randomized passes against a queue-based reference model.
module tb_dot_product;

    localparam int N  = 2;
    localparam int DW = 8;

    logic                 clk;
    logic                 reset;
    logic                 enable;
    logic signed [DW-1:0] in1 [0:N-1];
    logic signed [DW-1:0] in2 [0:N-1];
    logic signed [31:0]   sum;
    logic                 done;

    int checks;
    int errors;

    // Reference model: products collected for the pass in progress.
    int m_q[$];
    int m_sum;
    bit m_done;

    typedef struct {
        int a0;
        int a1;
        int b0;
        int b1;
        int exp_sum;
    } vec_t;

    vec_t vecs[6];

    dot_product #(
        .N (N),
        .DW(DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
        .inp1  (in1),
        .inp2  (in2),
        .sum   (sum),
        .done  (done)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", nm,
                     $signed(act), act, $signed(exp), exp);
        end
    endtask

    // Advance the model with the inputs present now, then cross one rising edge.
    task automatic tick();
        int s;
        if (reset) begin
            m_q.delete();
            m_sum  = 0;
            m_done = 1'b0;
        end else if (enable) begin
            m_q.push_back(int'(in1[m_q.size()]) * int'(in2[m_q.size()]));
            if (m_q.size() == N) begin
                s = 0;
                foreach (m_q[k]) s += m_q[k];
                m_sum  = s;
                m_done = 1'b1;
                m_q.delete();
            end else begin
                m_done = 1'b0;
            end
        end else begin
            m_done = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string nm);
        check({nm, "_sum"}, sum, m_sum);
        check({nm, "_done"}, {31'b0, done}, {31'b0, m_done});
    endtask

    task automatic set_inputs(input int a0, input int a1, input int b0, input int b1);
        in1[0] = DW'(a0);
        in1[1] = DW'(a1);
        in2[0] = DW'(b0);
        in2[1] = DW'(b1);
    endtask

    task automatic do_reset(input int cycles);
        reset  = 1'b1;
        enable = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_sum  = 0;
        m_done = 1'b0;
        reset  = 1'b0;
        enable = 1'b0;
        set_inputs(0, 0, 0, 0);

        vecs[0] = '{1, 2, 3, 4, 11};
        vecs[1] = '{-1, 2, 3, -4, -11};
        vecs[2] = '{-128, -128, -128, -128, 32768};
        vecs[3] = '{127, 127, 127, 127, 32258};
        vecs[4] = '{-128, 127, 127, -128, -32512};
        vecs[5] = '{0, 0, 5, 6, 0};

        // Reset held two cycles.
        do_reset(2);
        check("reset_sum", sum, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);

        // Table vectors: fresh reset, then one full pass.
        for (int v = 0; v < 6; v++) begin
            do_reset(1);
            set_inputs(vecs[v].a0, vecs[v].a1, vecs[v].b0, vecs[v].b1);
            enable = 1'b1;
            tick();
            check("vec_mid_sum", sum, 32'd0);
            check("vec_mid_done", {31'b0, done}, 32'd0);
            tick();
            check("vec_sum", sum, 32'(vecs[v].exp_sum));
            check("vec_done", {31'b0, done}, 32'd1);
            check_model("vec_model");
        end

        // Continuous enable: done every second cycle, sum holds 11.
        do_reset(1);
        set_inputs(1, 2, 3, 4);
        enable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("cont_done", {31'b0, done}, (k % 2 == 1) ? 32'd1 : 32'd0);
            check("cont_sum", sum, (k >= 1) ? 32'd11 : 32'd0);
        end

        // Pause after the first element, then resume.
        do_reset(1);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("pause_done", {31'b0, done}, 32'd0);
            check("pause_sum", sum, 32'd0);
        end
        enable = 1'b1;
        tick();
        check("resume_sum", sum, 32'd11);
        check("resume_done", {31'b0, done}, 32'd1);

        // Reset mid-pass (idx = 1) abandons the partial result.
        do_reset(1);
        set_inputs(5, 5, 5, 5);
        enable = 1'b1;
        tick();
        tick();
        check("pre_rst_sum", sum, 32'd50);
        set_inputs(1, 2, 3, 4);
        tick();
        reset = 1'b1;
        tick();
        check("midrst_sum", sum, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        reset = 1'b0;
        tick();
        check("after_rst_mid", sum, 32'd0);
        tick();
        check("after_rst_sum", sum, 32'd11);
        check("after_rst_done", {31'b0, done}, 32'd1);

        // Randomized passes with random enable gaps and occasional resets.
        do_reset(1);
        for (int c = 0; c < 400; c++) begin
            if (m_q.size() == 0)
                set_inputs($urandom_range(0, 255), $urandom_range(0, 255),
                           $urandom_range(0, 255), $urandom_range(0, 255));
            enable = ($urandom_range(0, 3) != 0);
            reset  = ($urandom_range(0, 40) == 0);
            tick();
            check_model("rand");
        end
        reset  = 1'b0;
        enable = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
